cpu_boot_ctrl: RTL

Boot and run sequencer for the single-cycle RISC-V core (t1c_riscv_cpu). Holds the core in reset, streams a program image into core memory through its external write port (Ext_MemWrite/Ext_WriteData/Ext_DataAdr), releases reset, then monitors core stores for a pass/fail signature or a timeout. The core is re-parked in reset on completion. Sits between a host/loader stream and the core's top-level pins.

---
 rtl/cpu_boot_pkg.sv | 18 +
 rtl/cpu_boot_ctrl_if.sv | 32 +++
 rtl/cpu_store_checker.sv | 27 ++
 rtl/cpu_boot_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the boot/run sequencer.
package cpu_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_STORE    = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAIL_OVERFLOW = 2'd3;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Host loader stream, core pins and status bundled for the boot sequencer.
// slave = the sequencer, master = host/core side driving it.
interface cpu_boot_ctrl_if;
  logic        start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] DataAdr;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;

  modport master (
    output start, load_valid, load_data, load_last, MemWrite, WriteData, DataAdr,
    input  load_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           busy, done, pass, fail_code
  );

  modport slave (
    input  start, load_valid, load_data, load_last, MemWrite, WriteData, DataAdr,
    output load_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           busy, done, pass, fail_code
  );
endinterface

// File: rtl/cpu_store_checker.sv
// Classifies a core store as the pass signature or a bad store. Scratch
// stores and idle cycles raise neither flag. Kept combinational so the
// FSM's own registers sample the store on the same edge the core issues it.
module cpu_store_checker #(
  parameter logic [31:0] DONE_ADR    = 32'd100,
  parameter logic [31:0] DONE_DATA   = 32'd25,
  parameter logic [31:0] SCRATCH_ADR = 32'd96
) (
  input  logic        mem_write_i,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] write_data_i,
  output logic        pass_o,
  output logic        bad_o
);

  logic done_hit;
  logic scratch_hit;

  // Address/data compare of the current store.
  always_comb begin
    done_hit    = (data_adr_i == DONE_ADR) && (write_data_i == DONE_DATA);
    scratch_hit = (data_adr_i == SCRATCH_ADR);
    pass_o      = mem_write_i && done_hit;
    bad_o       = mem_write_i && !done_hit && !scratch_hit;
  end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot and run sequencer: parks the core in reset, streams an image into
// core memory, runs the core and watches its stores for a signature.
//
// state | meaning
// IDLE  | core parked, waiting for start
// LOAD  | accepting image beats, one memory write per beat
// HOLD  | one cycle to let the final write land before release
// RUN   | core out of reset, stores monitored, run timer counting
// PASS  | pass signature seen, core parked, status held
// FAIL  | bad store / timeout / overflow, core parked, status held
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE   = 32'd0,
  parameter int          MAX_WORDS   = 64,
  parameter logic [31:0] DONE_ADR    = 32'd100,
  parameter logic [31:0] DONE_DATA   = 32'd25,
  parameter logic [31:0] SCRATCH_ADR = 32'd96,
  parameter int          TIMEOUT_CYC = 1024
) (
  input logic             clk,
  input logic             reset,
  cpu_boot_ctrl_if.slave  bus
);

  localparam int WW = ($clog2(MAX_WORDS + 1) > 7) ? $clog2(MAX_WORDS + 1) : 7;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    fail_q, fail_d;
  logic          ext_we_q, ext_we_d;
  logic [31:0]   ext_wd_q, ext_wd_d;
  logic [31:0]   ext_adr_q, ext_adr_d;
  logic          load_ready_q, cpu_reset_q, busy_q, done_q, pass_q;
  logic          st_pass, st_bad;

  cpu_store_checker #(
    .DONE_ADR    (DONE_ADR),
    .DONE_DATA   (DONE_DATA),
    .SCRATCH_ADR (SCRATCH_ADR)
  ) u_chk (
    .mem_write_i  (bus.MemWrite),
    .data_adr_i   (bus.DataAdr),
    .write_data_i (bus.WriteData),
    .pass_o       (st_pass),
    .bad_o        (st_bad)
  );

  // Next-state, counters and memory-write request.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cyc_d     = cyc_q;
    fail_d    = fail_q;
    ext_we_d  = 1'b0;
    ext_wd_d  = ext_wd_q;
    ext_adr_d = ext_adr_q;
    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
          cyc_d   = '0;
          fail_d  = FAIL_NONE;
        end
      end
      ST_LOAD: begin
        if (bus.load_valid && load_ready_q) begin
          if (wcnt_q == WW'(MAX_WORDS)) begin
            // Image would exceed capacity: drop the beat, no write.
            state_d = ST_FAIL;
            fail_d  = FAIL_OVERFLOW;
          end else begin
            ext_we_d  = 1'b1;
            ext_wd_d  = bus.load_data;
            ext_adr_d = LOAD_BASE + (32'(wcnt_q) << 2);
            wcnt_d    = wcnt_q + WW'(1);
            if (bus.load_last) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: state_d = ST_RUN;
      ST_RUN: begin
        cyc_d = cyc_q + CW'(1);
        // Pass store wins over bad store, which wins over timeout.
        if (st_pass) begin
          state_d = ST_PASS;
        end else if (st_bad) begin
          state_d = ST_FAIL;
          fail_d  = FAIL_STORE;
        end else if (cyc_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = ST_FAIL;
          fail_d  = FAIL_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      cyc_q        <= '0;
      fail_q       <= FAIL_NONE;
      ext_we_q     <= 1'b0;
      ext_wd_q     <= '0;
      ext_adr_q    <= '0;
      load_ready_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      cyc_q        <= cyc_d;
      fail_q       <= fail_d;
      ext_we_q     <= ext_we_d;
      ext_wd_q     <= ext_wd_d;
      ext_adr_q    <= ext_adr_d;
      load_ready_q <= (state_d == ST_LOAD);
      cpu_reset_q  <= (state_d != ST_RUN);
      busy_q       <= (state_d == ST_LOAD) || (state_d == ST_HOLD) || (state_d == ST_RUN);
      done_q       <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_q       <= (state_d == ST_PASS);
    end
  end

  assign bus.load_ready    = load_ready_q;
  assign bus.cpu_reset     = cpu_reset_q;
  assign bus.Ext_MemWrite  = ext_we_q;
  assign bus.Ext_WriteData = ext_wd_q;
  assign bus.Ext_DataAdr   = ext_adr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail_code     = fail_q;

endmodule
